// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_pkg
//  Purpose  : Shared fetch-side definitions: instruction widths used by the
//             fetch unit and the instruction queue, the substitute NOP word
//             and the fetch state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int unsigned c_ILEN    = 32;          // fetched word width
  localparam int unsigned c_INSTR_W = c_ILEN - 2;  // queue entry width, [1:0] dropped

  localparam logic [c_ILEN-1:0] c_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [0:0] {
    RUN   = 1'b0,  // normal issue / buffer
    DRAIN = 1'b1   // stale responses still owed from before a redirect
  } fetch_state_e;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_skid_buf
//  Purpose  : Small circular FIFO that catches memory responses so that no
//             returned word is lost while the instruction queue is full.
//  Ports    : clock, resetn     - clock, async active-low reset
//             clear             - drop all entries (highest priority)
//             push, din         - write one word
//             pop               - retire the head word
//             count             - number of valid entries
//             head              - oldest word (valid when count != 0)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_skid_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wptr_nxt;
  logic [PW-1:0]    w_rptr_nxt;

  // Explicit wrap keeps non-power-of-two depths correct as well.
  assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

  assign count = r_count;
  assign head  = r_mem[r_rptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= w_wptr_nxt;
      if (pop)  r_rptr <= w_rptr_nxt;
      // Simultaneous push and pop on a full buffer leaves count unchanged;
      // the write lands in the slot the pop is vacating.
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every use of the contents.
  always_ff @(posedge clock) begin
    if (push && !clear) r_mem[r_wptr] <= din;
  end

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. Issues word-aligned requests to
//             instruction memory, buffers in-order responses in a skid
//             buffer, pushes them into the instruction queue (replacing
//             non-32-bit encodings with NOP) and discards stale responses
//             after a redirect.
//  Ports    : clock, resetn                 - clock, async active-low reset
//             redirect, redirectPc          - branch/exception redirect
//             memReq, memAddr, memGnt       - request channel
//             memRvalid, memRdata           - in-order response channel
//             queueFull, push, instrOut     - instruction queue write side
//             queueFlush                    - queue flush (same cycle)
//             fetchFault                    - NOP substitution pulse
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN            = 32,
  parameter logic [XLEN-1:0]  RESET_PC        = '0,
  parameter int               MAX_OUTSTANDING = 2,
  parameter logic [c_ILEN-1:0] NOP            = c_NOP
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirectPc,
  output logic                 memReq,
  output logic [XLEN-1:0]      memAddr,
  input  logic                 memGnt,
  input  logic                 memRvalid,
  input  logic [c_ILEN-1:0]    memRdata,
  input  logic                 queueFull,
  output logic                 push,
  output logic [c_INSTR_W-1:0] instrOut,
  output logic                 queueFlush,
  output logic                 fetchFault
);

  localparam int              c_CW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [XLEN-1:0] c_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  logic                r_rst_done;   // first clock edge after reset release seen
  logic [XLEN-1:0]     r_pc;
  logic [c_CW-1:0]     r_outstanding;
  logic [c_CW-1:0]     r_drop_count;
  fetch_state_e        r_state;

  logic [c_CW-1:0]     w_buf_count;
  logic [c_ILEN-1:0]   w_buf_head;
  logic [c_CW:0]       w_inflight;
  logic                w_redirect;
  logic                w_grant;
  logic                w_rsp;
  logic                w_discard;
  logic                w_buf_push;
  logic                w_word_ok;
  logic [c_CW-1:0]     w_drop_nxt;

  assign w_redirect = redirect & r_rst_done;
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_buf_count};

  // Request stays up until granted: the in-flight total can only shrink
  // while ungranted, so only a redirect can pull it down.
  assign memReq  = r_rst_done & ~redirect &
                   (w_inflight < (c_CW+1)'(MAX_OUTSTANDING));
  assign memAddr = r_pc & c_ALIGN;
  assign w_grant = memReq & memGnt;

  // A response with nothing outstanding belongs to a request abandoned by
  // reset and is ignored.
  assign w_rsp      = memRvalid & (r_outstanding != '0);
  assign w_discard  = w_rsp & (r_state == DRAIN);
  assign w_buf_push = w_rsp & ~w_discard & ~w_redirect;

  // No push on the flush cycle, so a stale word cannot slip into the
  // queue while it is being flushed.
  assign push       = (w_buf_count != '0) & ~queueFull & ~w_redirect;
  assign w_word_ok  = (w_buf_head[1:0] == 2'b11);
  assign instrOut   = (w_buf_count == '0) ? '0 :
                      (w_word_ok ? w_buf_head[c_ILEN-1:2] : NOP[c_ILEN-1:2]);
  assign fetchFault = push & ~w_word_ok;
  assign queueFlush = w_redirect;

  // Every outstanding request (already-owed drops included) becomes a drop
  // on redirect, less any response retiring in the same cycle. No grant can
  // occur on a redirect cycle because memReq is forced low.
  always_comb begin
    w_drop_nxt = r_drop_count;
    if (w_redirect)     w_drop_nxt = r_outstanding - c_CW'(w_rsp);
    else if (w_discard) w_drop_nxt = r_drop_count - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rst_done    <= 1'b0;
      r_pc          <= RESET_PC & c_ALIGN;
      r_outstanding <= '0;
      r_drop_count  <= '0;
      r_state       <= RUN;
    end else begin
      r_rst_done    <= 1'b1;
      if (w_redirect)   r_pc <= redirectPc & c_ALIGN;
      else if (w_grant) r_pc <= r_pc + XLEN'(4);
      r_outstanding <= r_outstanding + c_CW'(w_grant) - c_CW'(w_rsp);
      r_drop_count  <= w_drop_nxt;
      r_state       <= (w_drop_nxt != '0) ? DRAIN : RUN;
    end
  end

  fetch_skid_buf #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (c_ILEN)
  ) u_skid (
    .clock  (clock),
    .resetn (resetn),
    .clear  (w_redirect),
    .push   (w_buf_push),
    .din    (memRdata),
    .pop    (push),
    .count  (w_buf_count),
    .head   (w_buf_head)
  );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit with a one-cycle-latency
//             instruction memory model and an in-order push scoreboard.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        resetn;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        queueFull;
  logic        push;
  logic [29:0] instrOut;
  logic        queueFlush;
  logic        fetchFault;

  int checks   = 0;
  int failures = 0;
  int push_cnt = 0;

  logic [31:0] pending[$];    // granted addresses awaiting a response
  logic [31:0] expq[$];       // granted addresses whose word is still owed
  logic [31:0] grant_log[$];

  logic        ctl_gnt    = 1'b0;
  logic        ctl_mem_en = 1'b0;
  logic        ctl_qfull  = 1'b0;
  logic        ctl_redir  = 1'b0;
  logic [31:0] ctl_rpc    = '0;

  always #5 clock = ~clock;

  fetch_unit #(
    .XLEN            (32),
    .RESET_PC        (RST_PC),
    .MAX_OUTSTANDING (2),
    .NOP             (32'h0000_0013)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memGnt     (memGnt),
    .memRvalid  (memRvalid),
    .memRdata   (memRdata),
    .queueFull  (queueFull),
    .push       (push),
    .instrOut   (instrOut),
    .queueFlush (queueFlush),
    .fetchFault (fetchFault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h0000_4501;
    return {a[27:0], 4'h3};
  endfunction

  // One clock: drive inputs just after the rising edge, return just after
  // the falling edge so callers sample settled outputs.
  task automatic tick();
    @(posedge clock);
    #1;
    memGnt     = ctl_gnt;
    queueFull  = ctl_qfull;
    redirect   = ctl_redir;
    redirectPc = ctl_rpc;
    ctl_redir  = 1'b0;
    if (ctl_mem_en && pending.size() != 0) begin
      memRvalid = 1'b1;
      memRdata  = mem_word(pending.pop_front());
    end else begin
      memRvalid = 1'b0;
      memRdata  = '0;
    end
    @(negedge clock);
    #1;
  endtask

  // Scoreboard: record grants, compare every push against the oldest owed word.
  always @(negedge clock) begin : mon
    logic [31:0] a, w;
    logic [29:0] ei;
    logic        ef;
    if (!resetn) begin
      expq.delete();
    end else begin
      if (push) begin
        push_cnt++;
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_push: instrOut=%h, no push expected", instrOut);
        end else begin
          a  = expq.pop_front();
          w  = mem_word(a);
          ei = (w[1:0] == 2'b11) ? w[31:2] : 30'h4;
          ef = (w[1:0] != 2'b11);
          if (instrOut !== ei || fetchFault !== ef) begin
            failures++;
            $display("FAIL sb_push addr=%h: instrOut=%h fetchFault=%b expected %h %b",
                     a, instrOut, fetchFault, ei, ef);
          end
        end
      end
      if (memReq && memGnt) begin
        pending.push_back(memAddr);
        expq.push_back(memAddr);
        grant_log.push_back(memAddr);
      end
      if (redirect) expq.delete();
    end
  end

  task automatic test_reset();
    ctl_gnt = 1'b1; ctl_mem_en = 1'b1;
    repeat (3) tick();
    checks++; if (memReq !== 1'b0)     begin failures++; $display("FAIL reset_memReq: got %b expected 0", memReq); end
    checks++; if (push !== 1'b0)       begin failures++; $display("FAIL reset_push: got %b expected 0", push); end
    checks++; if (queueFlush !== 1'b0) begin failures++; $display("FAIL reset_queueFlush: got %b expected 0", queueFlush); end
    checks++; if (fetchFault !== 1'b0) begin failures++; $display("FAIL reset_fetchFault: got %b expected 0", fetchFault); end
    checks++; if (instrOut !== 30'h0)  begin failures++; $display("FAIL reset_instrOut: got %h expected 0", instrOut); end
  endtask

  task automatic test_sequence();
    logic [31:0] w;
    grant_log.delete();
    resetn = 1'b1;
    tick();
    checks++; if (memReq !== 1'b1)  begin failures++; $display("FAIL first_memReq: got %b expected 1", memReq); end
    checks++; if (memAddr !== RST_PC) begin failures++; $display("FAIL first_memAddr: got %h expected %h", memAddr, RST_PC); end
    repeat (2) tick();
    w = mem_word(RST_PC);
    checks++; if (push !== 1'b1) begin failures++; $display("FAIL first_push_latency: push=%b expected 1", push); end
    checks++; if (instrOut !== w[31:2]) begin failures++; $display("FAIL first_push_data: got %h expected %h", instrOut, w[31:2]); end
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_log.size() <= i || grant_log[i] !== RST_PC + 32'(4 * i)) begin
        failures++;
        $display("FAIL pc_sequence[%0d]: got %h expected %h", i,
                 (grant_log.size() > i) ? grant_log[i] : 32'hxxxx_xxxx, RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_queue_full();
    int p0;
    ctl_qfull = 1'b1;
    p0 = push_cnt;
    repeat (10) tick();
    checks++; if (memReq !== 1'b0)     begin failures++; $display("FAIL qfull_memReq: got %b expected 0", memReq); end
    checks++; if (expq.size() != 2)    begin failures++; $display("FAIL qfull_inflight: got %0d expected 2", expq.size()); end
    checks++; if (push_cnt != p0)      begin failures++; $display("FAIL qfull_no_push: got %0d pushes expected 0", push_cnt - p0); end
    ctl_qfull = 1'b0;
    tick();
    checks++; if (push !== 1'b1) begin failures++; $display("FAIL qfull_release_push0: got %b expected 1", push); end
    tick();
    checks++; if (push !== 1'b1) begin failures++; $display("FAIL qfull_release_push1: got %b expected 1", push); end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] w;
    logic        found;
    ctl_mem_en = 1'b0;
    repeat (4) tick();
    checks++; if (pending.size() != 2) begin failures++; $display("FAIL drain_outstanding: got %0d expected 2", pending.size()); end
    ctl_redir = 1'b1; ctl_rpc = 32'h0000_2000;
    tick();
    checks++; if (queueFlush !== 1'b1) begin failures++; $display("FAIL drain_queueFlush: got %b expected 1", queueFlush); end
    checks++; if (memReq !== 1'b0)     begin failures++; $display("FAIL drain_memReq_redirect: got %b expected 0", memReq); end
    ctl_mem_en = 1'b1;
    tick();
    checks++; if (memAddr !== 32'h0000_2000) begin failures++; $display("FAIL drain_memAddr: got %h expected 00002000", memAddr); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (push) found = 1'b1; else tick();
    end
    w = mem_word(32'h0000_2000);
    checks++;
    if (!found) begin failures++; $display("FAIL drain_first_push: no push within 12 cycles, expected one"); end
    else if (instrOut !== w[31:2]) begin failures++; $display("FAIL drain_first_push: got %h expected %h", instrOut, w[31:2]); end
  endtask

  task automatic test_compressed();
    logic found;
    ctl_redir = 1'b1; ctl_rpc = 32'h0000_3000;
    tick();
    checks++; if (queueFlush !== 1'b1) begin failures++; $display("FAIL cmp_queueFlush: got %b expected 1", queueFlush); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (push) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL cmp_push: no push within 12 cycles, expected one"); end
    else if (instrOut !== 30'h4 || fetchFault !== 1'b1) begin
      failures++; $display("FAIL cmp_nop: instrOut=%h fetchFault=%b expected 00000004 1", instrOut, fetchFault);
    end
    tick();
    checks++; if (fetchFault !== 1'b0) begin failures++; $display("FAIL cmp_fault_pulse: got %b expected 0", fetchFault); end
  endtask

  task automatic test_redirect_collision();
    logic [31:0] w;
    logic        found;
    int          gl;
    for (int i = 0; i < 6 && pending.size() == 0; i++) tick();
    gl = grant_log.size();
    ctl_redir = 1'b1; ctl_rpc = 32'h0000_4000;
    tick();
    checks++; if (memReq !== 1'b0 || queueFlush !== 1'b1 || memRvalid !== 1'b1) begin
      failures++; $display("FAIL coll_cycle: memReq=%b queueFlush=%b memRvalid=%b expected 0 1 1", memReq, queueFlush, memRvalid);
    end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (push) found = 1'b1;
    end
    w = mem_word(32'h0000_4000);
    checks++;
    if (!found) begin failures++; $display("FAIL coll_push: no push within 12 cycles, expected one"); end
    else if (instrOut !== w[31:2]) begin failures++; $display("FAIL coll_push: got %h expected %h", instrOut, w[31:2]); end
    checks++;
    if (grant_log.size() <= gl || grant_log[gl] !== 32'h0000_4000) begin
      failures++; $display("FAIL coll_restart_pc: got %h expected 00004000",
                           (grant_log.size() > gl) ? grant_log[gl] : 32'hxxxx_xxxx);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] w;
    ctl_gnt = 1'b0; ctl_mem_en = 1'b1;
    repeat (4) tick();
    ctl_gnt = 1'b1; ctl_mem_en = 1'b0;
    tick();
    ctl_gnt = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    checks++; if (memReq !== 1'b0 || push !== 1'b0 || queueFlush !== 1'b0 ||
                  fetchFault !== 1'b0 || instrOut !== 30'h0) begin
      failures++; $display("FAIL midreset_outputs: memReq=%b push=%b flush=%b fault=%b instr=%h expected all 0",
                           memReq, push, queueFlush, fetchFault, instrOut);
    end
    repeat (2) tick();
    resetn = 1'b1; ctl_gnt = 1'b1; ctl_mem_en = 1'b1;
    tick();
    checks++; if (memReq !== 1'b1 || memAddr !== RST_PC) begin
      failures++; $display("FAIL midreset_restart: memReq=%b memAddr=%h expected 1 %h", memReq, memAddr, RST_PC);
    end
    tick();
    checks++; if (push !== 1'b0) begin failures++; $display("FAIL midreset_late_rvalid: push=%b expected 0", push); end
    tick();
    w = mem_word(RST_PC);
    checks++; if (push !== 1'b1 || instrOut !== w[31:2]) begin
      failures++; $display("FAIL midreset_first_push: push=%b instrOut=%h expected 1 %h", push, instrOut, w[31:2]);
    end
  endtask

  initial begin
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0; queueFull = 1'b0;
    redirect = 1'b0; redirectPc = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    test_reset();
    test_sequence();
    test_queue_full();
    test_redirect_drain();
    test_compressed();
    test_redirect_collision();
    test_reset_midflight();
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
